// File: rtl/qpsk_tx_framer_if.sv
// Upstream payload byte stream (valid/ready) feeding the QPSK frame sequencer.
interface qpsk_tx_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/qpsk_tx_framer.sv
// QPSK frame sequencer: preamble, sync word, length byte, payload, then a silent
// guard interval; one dibit per modulator symbol strobe, MSB-first.
module qpsk_tx_framer #(
  parameter int unsigned PREAMBLE_SYMS = 32,
  parameter logic [15:0] SYNC_WORD     = 16'hD391,
  parameter int unsigned GUARD_SYMS    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [7:0]              frame_len,
  qpsk_tx_framer_if.slave         s_if,
  input  logic                    mod_req,
  output logic [1:0]              symbol_out,
  output logic                    symbol_en,
  output logic                    busy,
  output logic                    done,
  output logic                    underrun
);

  typedef enum logic [2:0] {IDLE, PRE, SYNC, LEN, PAY, GUARD} state_t;

  state_t      r_state, w_state, w_seg;
  logic [15:0] r_sym_cnt, w_sym_cnt, w_idx, w_seg_len, w_sync_sh;
  logic [7:0]  r_len, w_len, w_len_sh;
  logic [8:0]  r_byte_cnt, w_byte_cnt, r_fetch_cnt, w_fetch_cnt;
  logic [7:0]  r_pf_data, w_pf_data, r_shift, w_shift;
  logic        r_pf_valid, w_pf_valid;
  logic [1:0]  r_sym, w_sym;
  logic        r_en, w_en, r_busy, w_busy, r_done, w_done;
  logic        r_underrun, w_underrun, r_ready, w_ready, w_xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sym_cnt   <= '0;
      r_len       <= '0;
      r_byte_cnt  <= '0;
      r_fetch_cnt <= '0;
      r_pf_data   <= '0;
      r_pf_valid  <= 1'b0;
      r_shift     <= '0;
      r_sym       <= '0;
      r_en        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_underrun  <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sym_cnt   <= w_sym_cnt;
      r_len       <= w_len;
      r_byte_cnt  <= w_byte_cnt;
      r_fetch_cnt <= w_fetch_cnt;
      r_pf_data   <= w_pf_data;
      r_pf_valid  <= w_pf_valid;
      r_shift     <= w_shift;
      r_sym       <= w_sym;
      r_en        <= w_en;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_underrun  <= w_underrun;
      r_ready     <= w_ready;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_sym_cnt   = r_sym_cnt;
    w_len       = r_len;
    w_byte_cnt  = r_byte_cnt;
    w_fetch_cnt = r_fetch_cnt;
    w_pf_data   = r_pf_data;
    w_pf_valid  = r_pf_valid;
    w_shift     = r_shift;
    w_sym       = r_sym;
    w_en        = r_en;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_underrun  = 1'b0;
    w_seg       = r_state;
    w_idx       = r_sym_cnt;
    w_seg_len   = '0;
    w_sync_sh   = '0;
    w_len_sh    = '0;
    w_xfer      = s_if.s_valid && r_ready;

    case (r_state)
      IDLE: begin
        w_sym = '0;
        w_en  = 1'b0;
        if (start) begin
          w_len       = frame_len;
          w_busy      = 1'b1;
          w_state     = PRE;
          w_sym_cnt   = '0;
          w_byte_cnt  = '0;
          w_fetch_cnt = '0;
          w_pf_valid  = 1'b0;
        end
      end
      PRE, SYNC, LEN, PAY: begin
        if (mod_req) begin
          // r_sym_cnt counts symbols already sent in the current segment; when it is
          // full, this strobe loads symbol 0 of the following segment.
          case (r_state)
            PRE:     w_seg_len = 16'(PREAMBLE_SYMS);
            SYNC:    w_seg_len = 16'd8;
            default: w_seg_len = 16'd4;
          endcase
          if (r_sym_cnt == w_seg_len) begin
            w_idx = '0;
            case (r_state)
              PRE:     w_seg = SYNC;
              SYNC:    w_seg = LEN;
              LEN:     w_seg = (r_len == 8'd0) ? GUARD : PAY;
              default: w_seg = (r_byte_cnt == {1'b0, r_len}) ? GUARD : PAY;
            endcase
          end
          w_sync_sh = SYNC_WORD << {w_idx[2:0], 1'b0};
          w_len_sh  = r_len << {w_idx[1:0], 1'b0};
          w_sym_cnt = w_idx + 16'd1;
          w_en      = 1'b1;
          case (w_seg)
            PRE:  w_sym = w_idx[0] ? 2'b10 : 2'b00;
            SYNC: w_sym = w_sync_sh[15:14];
            LEN:  w_sym = w_len_sh[7:6];
            PAY: begin
              if (w_idx == 16'd0) begin
                if (r_pf_valid) begin
                  w_sym      = r_pf_data[7:6];
                  w_shift    = {r_pf_data[5:0], 2'b00};
                  w_pf_valid = 1'b0;
                  w_byte_cnt = r_byte_cnt + 9'd1;
                end else begin
                  w_seg      = GUARD;
                  w_underrun = 1'b1;
                end
              end else begin
                w_sym   = r_shift[7:6];
                w_shift = {r_shift[5:0], 2'b00};
              end
            end
            default: ;
          endcase
          if (w_seg == GUARD) begin
            w_sym     = '0;
            w_en      = 1'b0;
            w_sym_cnt = '0;
          end
          w_state = w_seg;
        end
      end
      GUARD: begin
        if (mod_req) begin
          if (r_sym_cnt == 16'(GUARD_SYMS - 1)) begin
            w_done    = 1'b1;
            w_busy    = 1'b0;
            w_state   = IDLE;
            w_sym_cnt = '0;
          end else begin
            w_sym_cnt = r_sym_cnt + 16'd1;
          end
        end
      end
      default: w_state = IDLE;
    endcase

    if (w_xfer) begin
      w_pf_data   = s_if.s_data;
      w_pf_valid  = 1'b1;
      w_fetch_cnt = r_fetch_cnt + 9'd1;
    end
    // Bytes still prefetched when the frame ends are dropped.
    if (w_state == IDLE) w_pf_valid = 1'b0;

    w_ready = w_busy && !w_pf_valid && (w_fetch_cnt < {1'b0, w_len}) &&
              (w_state != GUARD) && (w_state != IDLE);
  end

  assign s_if.s_ready = r_ready;
  assign symbol_out   = r_sym;
  assign symbol_en    = r_en;
  assign busy         = r_busy;
  assign done         = r_done;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_qpsk_tx_framer.sv
// Directed bench for qpsk_tx_framer: per-strobe expected slots in a scoreboard queue.
module tb_qpsk_tx_framer;

  localparam int unsigned P = 4;
  localparam int unsigned G = 2;

  typedef struct packed {
    logic [1:0] sym;
    logic       en;
    logic       dn;
    logic       un;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, start, mod_req;
  logic [7:0] frame_len;
  logic [1:0] symbol_out;
  logic       symbol_en, busy, done, underrun;

  qpsk_tx_framer_if s_if ();

  qpsk_tx_framer #(
    .PREAMBLE_SYMS(P),
    .SYNC_WORD(16'hD391),
    .GUARD_SYMS(G)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .frame_len(frame_len),
    .s_if(s_if), .mod_req(mod_req), .symbol_out(symbol_out),
    .symbol_en(symbol_en), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] src_q[$];
  bit         src_rnd = 1'b0;
  int         n_acc = 0, n_rdy = 0;
  int         n_vec = 0, n_err = 0;

  // Upstream source: drives on negedge, samples the handshake just before posedge.
  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    forever begin
      @(negedge clk);
      if (src_q.size() > 0 && (!src_rnd || $urandom_range(0, 1) == 1)) begin
        s_if.s_valid = 1'b1;
        s_if.s_data  = src_q[0];
      end else begin
        s_if.s_valid = 1'b0;
      end
      #4;
      if (s_if.s_ready) n_rdy++;
      if (s_if.s_valid && s_if.s_ready && src_q.size() > 0) begin
        void'(src_q.pop_front());
        n_acc++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] obs();
    return {2'b00, symbol_out, symbol_en, done, underrun, busy};
  endfunction

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic push(input logic [1:0] s, input logic en, input logic dn, input logic un);
    exp_t e;
    e.sym = s; e.en = en; e.dn = dn; e.un = un;
    exp_q.push_back(e);
  endtask

  task automatic build_frame(input logic [7:0] len, input int avail);
    logic [15:0] sw;
    logic [7:0]  b;
    bit          unr;
    sw  = 16'hD391;
    unr = 1'b0;
    for (int i = 0; i < int'(P); i++) push((i % 2 == 1) ? 2'b10 : 2'b00, 1, 0, 0);
    for (int i = 0; i < 8; i++) push(sw[15-2*i -: 2], 1, 0, 0);
    for (int i = 0; i < 4; i++) push(len[7-2*i -: 2], 1, 0, 0);
    for (int k = 0; k < int'(len); k++) begin
      if (k < avail) begin
        b = pay_q[k];
        for (int j = 0; j < 4; j++) push(b[7-2*j -: 2], 1, 0, 0);
      end else begin
        push(2'b00, 0, 0, 1);
        unr = 1'b1;
        break;
      end
    end
    if (!unr) push(2'b00, 0, 0, 0);
    for (int g = 0; g < int'(G) - 1; g++) push(2'b00, 0, 0, 0);
    push(2'b00, 0, 1, 0);
  endtask

  task automatic setup(input logic [7:0] len, input int avail, input logic [7:0] b0, input logic [7:0] b1);
    pay_q.delete();
    src_q.delete();
    for (int k = 0; k < int'(len); k++) begin
      if (k == 0) pay_q.push_back(b0);
      else if (k == 1) pay_q.push_back(b1);
      else pay_q.push_back(8'($urandom_range(0, 255)));
    end
    for (int k = 0; k < avail; k++) src_q.push_back(pay_q[k]);
    n_acc = 0;
    n_rdy = 0;
    build_frame(len, avail);
  endtask

  task automatic begin_frame(input logic [7:0] len, input logic with_req);
    @(negedge clk);
    start = 1'b1; frame_len = len; mod_req = with_req;
    @(negedge clk);
    start = 1'b0; mod_req = 1'b0;
    chk("start", obs(), 8'h01);
    repeat (2) @(negedge clk);
    chk("start_hold", obs(), 8'h01);
  endtask

  task automatic strobe_check();
    exp_t e;
    @(negedge clk);
    mod_req = 1'b1;
    @(negedge clk);
    mod_req = 1'b0;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 8'h01, 8'h00);
      return;
    end
    e = exp_q.pop_front();
    chk("slot", obs(), {2'b00, e.sym, e.en, e.dn, e.un, ~e.dn});
    repeat (6) begin
      @(negedge clk);
      chk("hold", obs(), {2'b00, e.sym, e.en, 2'b00, ~e.dn});
    end
  endtask

  task automatic run_strobes(input int n);
    for (int k = 0; k < n; k++) strobe_check();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mod_req = 1'b0; frame_len = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {1'b0, s_if.s_ready, obs()[5:0]}, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal frame: B4, 1E
    setup(8'd2, 2, 8'hB4, 8'h1E);
    begin_frame(8'd2, 1'b0);
    run_strobes(exp_q.size());
    chk("nom_bytes", 8'(n_acc), 8'd2);

    // Header-only frame
    setup(8'd0, 0, 8'h00, 8'h00);
    begin_frame(8'd0, 1'b0);
    run_strobes(exp_q.size());
    chk("hdr_ready", 8'(n_rdy), 8'd0);

    // Underrun: 3 bytes announced, only 1 supplied
    setup(8'd3, 1, 8'h5A, 8'h00);
    begin_frame(8'd3, 1'b0);
    run_strobes(exp_q.size());
    chk("unr_bytes", 8'(n_acc), 8'd1);

    // Random back-pressure
    src_rnd = 1'b1;
    setup(8'd5, 5, 8'hC3, 8'h27);
    begin_frame(8'd5, 1'b0);
    run_strobes(exp_q.size());
    chk("bp_bytes", 8'(n_acc), 8'd5);
    src_rnd = 1'b0;

    // Start coincident with mod_req in IDLE, plus start pulsed mid-frame
    setup(8'd1, 1, 8'h96, 8'h00);
    begin_frame(8'd1, 1'b1);
    run_strobes(10);
    @(negedge clk);
    start = 1'b1; frame_len = 8'd7;
    @(negedge clk);
    start = 1'b0;
    run_strobes(exp_q.size());
    repeat (20) @(negedge clk);
    chk("no_refire", obs(), 8'h00);

    // Reset during PAY, then a clean frame
    setup(8'd3, 3, 8'hE1, 8'h4D);
    begin_frame(8'd3, 1'b0);
    run_strobes(int'(P) + 12 + 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset", {1'b0, s_if.s_ready, obs()[5:0]}, 8'h00);
    reset = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("post_reset", {1'b0, s_if.s_ready, obs()[5:0]}, 8'h00);
    setup(8'd2, 2, 8'hB4, 8'h1E);
    begin_frame(8'd2, 1'b0);
    run_strobes(exp_q.size());
    chk("rst_frame_bytes", 8'(n_acc), 8'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/qpsk_tx_framer.md
# qpsk_tx_framer

Frame sequencer that drives the QPSK modulator's symbol interface. On a start command it emits a preamble, a 16-bit sync word, a length byte and a payload, then a silent guard interval. Symbols are 2-bit dibits, MSB-first. Payload bytes are pulled from an upstream byte stream (valid/ready), and each symbol is advanced on the modulator's `mod_req` symbol-boundary strobe.

## Interface
- `PREAMBLE_SYMS`, 32: number of preamble symbols (≥1); alternating dibits 00,10,00,10,… starting with 00.
- `SYNC_WORD`, 16'hD391: sync word, sent as 8 dibits, MSB-first.
- `GUARD_SYMS`, 4: number of symbol slots (≥1) with `symbol_en`=0 after each frame.

Ports:
- `clk` in 1: system clock. One clock domain.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a frame. Sampled only in IDLE.
- `frame_len` in 8: payload byte count, latched when start is accepted. 0 means a header-only frame.
- `s_data` in 8: payload byte.
- `s_valid` in 1: upstream byte valid.
- `s_ready` out 1: controller accepts a byte. A transfer occurs when `s_valid`&&`s_ready`.
- `mod_req` in 1: one-cycle symbol-boundary strobe from the modulator.
- `symbol_out` out 2: dibit to the modulator's `symbol_in`.
- `symbol_en` out 1: to the modulator's `symbol_en`. Held for a whole symbol slot.
- `busy` out 1: a frame is in progress.
- `done` out 1: one-cycle pulse at end of frame, including after an abort.
- `underrun` out 1: one-cycle pulse when a payload byte is needed and none is buffered.

## Operation
- FSM states: IDLE, PRE, SYNC, LEN, PAY, GUARD.
- IDLE:
  - `symbol_en`=0 and `symbol_out`=00.
  - `start`=1 latches `frame_len`, sets `busy`, and goes to PRE.
  - `mod_req` is ignored in IDLE, including in the `start` cycle.
- Each state change, symbol load and counter advance happens only on a cycle with `mod_req`=1. Between strobes, `symbol_out` and `symbol_en` are held constant.
- PRE: emits `PREAMBLE_SYMS` alternating dibits.
- SYNC: emits 8 dibits of `SYNC_WORD`, MSB-first.
- LEN: emits 4 dibits of the latched `frame_len`, MSB-first.
- PAY: emits 4 dibits per byte, MSB-first, for `frame_len` bytes.
- If `frame_len`=0, LEN goes directly to GUARD.
- In PRE, SYNC, LEN and PAY, `symbol_en`=1.
- Byte buffering:
  - One prefetch register plus one 8-bit shift register.
  - `s_ready`=1 when busy, the prefetch register is empty, fetched count < `frame_len`, and state ≠ GUARD.
  - Prefetch therefore begins in PRE.
- On each `mod_req` that starts a new payload byte:
  - The prefetch register moves into the shift register and the prefetch register becomes empty.
  - A transfer in that same cycle refills the prefetch register; an explicit bypass to the shift register is not allowed.
- Underrun:
  - Condition: a new payload byte is needed and the prefetch register is empty.
  - Response: `symbol_en`←0, `underrun` pulses, and the FSM goes to GUARD.
  - The frame is aborted. Remaining upstream bytes are not drained. `s_ready`←0.
- GUARD:
  - `symbol_en`=0 and `symbol_out`=00.
  - Counts `GUARD_SYMS` strobes.
  - On the strobe that ends the last guard slot: `done`=1 for one cycle, `busy`←0, next state IDLE.
  - Leftover prefetched bytes are discarded.
- `start` while busy is ignored.
- Counters: symbol counter is 16 bits; byte counters are 9 bits. There is no wrap within a frame.

## Timing
- Reset values: `s_ready`=0, `symbol_out`=00, `symbol_en`=0, `busy`=0, `done`=0, `underrun`=0. FSM is in IDLE, counters and buffers are cleared.
- Reset asserted mid-frame returns to IDLE on the next edge without a `done` pulse.
- `busy` rises the cycle after `start` is accepted.
- Symbol load latency: `symbol_out`/`symbol_en` change on the edge that samples `mod_req`=1, i.e. one cycle after the strobe is high. The modulator sees the new symbol for the whole following slot.
- The first preamble symbol appears one cycle after the first `mod_req` that follows `start` acceptance.
- `done` and the `busy` fall occur on the same edge, one cycle after the last guard strobe.
- `underrun` is registered on the edge of the offending strobe.
- `s_ready` is registered and drops the cycle after a transfer.
- Total `symbol_en`-high slots per frame = `PREAMBLE_SYMS`+12+4·`frame_len`.

## Test plan
- Nominal frame:
  - Stimulus: `PREAMBLE_SYMS`=4, `GUARD_SYMS`=2, `mod_req` every 8 cycles, `frame_len`=2, bytes B4,1E always valid.
  - Required response, dibits: 00,10,00,10 | 11,01,00,11,10,01,00,01 | 00,00,00,10 | 10,11,01,00 | 00,01,11,10, then 2 slots with `symbol_en`=0, then a single `done` pulse.
- Header-only frame:
  - Stimulus: `frame_len`=0.
  - Required response: 16 enabled slots; `s_ready` never asserts; then guard, then `done`.
- Underrun:
  - Stimulus: `frame_len`=3; `s_valid` is dropped after 1 byte.
  - Required response: `underrun` pulses at the 5th payload strobe; `symbol_en`=0 from then; 2 guard slots; `done`; 0 further bytes accepted.
- Back-pressure and symbol stability:
  - Stimulus: `s_valid` toggles randomly, with each byte arriving before its deadline.
  - Required response: no underrun; `symbol_out` is stable between strobes; exact dibit sequence.
- Ignored start:
  - Stimulus: `start` pulsed mid-frame, and `start` coincident with `mod_req` in IDLE.
  - Required response: no second frame while busy; the first preamble symbol follows the next strobe.
- Reset mid-frame:
  - Stimulus: `reset` asserted during PAY.
  - Required response: all outputs at reset values on the next edge; no `done`; a new `start` produces a clean full frame.
